// File: rtl/elevator_pkg.sv
// Shared elevator definitions: default panel geometry and the controller state encoding.
package elevator_pkg;

   localparam int DEF_FLOORS = 8;
   localparam int DEF_POS_W  = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UP   = 3'd1,
      DOWN = 3'd2,
      STOP = 3'd3,
      DOOR = 3'd4
   } ctrl_state_t;

endpackage

// File: rtl/elevator_call_panel_if.sv
// Pin-side and controller-side signals of the call panel; the panel itself uses the slave view.
interface elevator_call_panel_if
   import elevator_pkg::*;
#(
   parameter int FLOORS = DEF_FLOORS,
   parameter int POS_W  = DEF_POS_W
);

   logic [FLOORS-1:0] btn_raw;
   logic [POS_W-1:0]  floor_pos;
   logic              door_open;
   logic [FLOORS-1:0] floor_req;
   logic [FLOORS-1:0] call_lamp;
   logic              chime;

   modport master (
      output btn_raw, floor_pos, door_open,
      input  floor_req, call_lamp, chime
   );

   modport slave (
      input  btn_raw, floor_pos, door_open,
      output floor_req, call_lamp, chime
   );

endinterface

// File: rtl/elevator_call_panel_debounce.sv
// One call button: 2-flop synchronizer, hold-time debounce counter and accepted level.
// o_press flags the cycle in which the accepted level is about to rise.
module call_debounce #(
   parameter int DEBOUNCE = 4,
   parameter int DEB_W    = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn_raw,
   output logic o_stable,
   output logic o_press
);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [DEB_W-1:0] r_cnt;
   logic             w_differs;
   logic             w_take;

   assign w_differs = (r_sync2 != r_stable);
   assign w_take    = w_differs && (r_cnt == DEB_W'(DEBOUNCE - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_btn_raw;
         r_sync2 <= r_sync1;
         if (!w_differs) begin
            r_cnt <= '0;
         end else if (w_take) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + DEB_W'(1);
         end
      end
   end

   assign o_stable = r_stable;
   assign o_press  = w_take && r_sync2;

endmodule

// File: rtl/elevator_call_panel.sv
// Call panel front end: debounced buttons -> one-cycle floor_req pulses plus per-floor call lamps.
// Optional arrival chime is built only when ARRIVAL_CHIME_EN is defined.
module elevator_call_panel
   import elevator_pkg::*;
#(
   parameter int FLOORS    = DEF_FLOORS,
   parameter int POS_W     = DEF_POS_W,
   parameter int DEBOUNCE  = 4,
   parameter int DEB_W     = 3,
   parameter int CHIME_LEN = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   elevator_call_panel_if.slave bus
);

   logic [FLOORS-1:0] w_press;
   logic [FLOORS-1:0] w_unused_stable;
   logic [FLOORS-1:0] w_svc;
   logic [FLOORS-1:0] w_req_next;
   logic [FLOORS-1:0] r_floor_req;
   logic [FLOORS-1:0] r_call_lamp;

   if ((2 ** POS_W) < FLOORS || (2 ** DEB_W) < DEBOUNCE || DEBOUNCE < 1 || CHIME_LEN < 1) begin : g_bad_param
      $error("elevator_call_panel: inconsistent parameters");
   end

   for (genvar f = 0; f < FLOORS; f++) begin : g_floor
      call_debounce #(
         .DEBOUNCE (DEBOUNCE),
         .DEB_W    (DEB_W)
      ) u_deb (
         .clk       (clk),
         .rst       (rst),
         .i_btn_raw (bus.btn_raw[f]),
         .o_stable  (w_unused_stable[f]),
         .o_press   (w_press[f])
      );

      // Out-of-range positions never match, so they clear nothing.
      assign w_svc[f] = bus.door_open && (bus.floor_pos == POS_W'(f))
                        && (int'(bus.floor_pos) < FLOORS);
   end

   // A press only requests service if nothing is pending and the door is not already open there.
   assign w_req_next = w_press & ~r_call_lamp & ~w_svc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_floor_req <= '0;
         r_call_lamp <= '0;
      end else begin
         r_floor_req <= w_req_next;
         r_call_lamp <= (r_call_lamp | w_req_next) & ~w_svc;
      end
   end

   assign bus.floor_req = r_floor_req;
   assign bus.call_lamp = r_call_lamp;

`ifdef ARRIVAL_CHIME_EN
   localparam int CHIME_W = $clog2(CHIME_LEN + 1);

   logic               r_door_open_q;
   logic [CHIME_W-1:0] r_chime_cnt;
   logic               w_door_rise;

   assign w_door_rise = bus.door_open && !r_door_open_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_door_open_q <= 1'b0;
         r_chime_cnt   <= '0;
      end else begin
         r_door_open_q <= bus.door_open;
         if (w_door_rise) begin
            r_chime_cnt <= CHIME_W'(CHIME_LEN);
         end else if (r_chime_cnt != '0) begin
            r_chime_cnt <= r_chime_cnt - CHIME_W'(1);
         end
      end
   end

   assign bus.chime = (r_chime_cnt != '0);
`else
   assign bus.chime = 1'b0;
`endif

endmodule

// File: tb/tb_elevator_call_panel.sv
// Bench for elevator_call_panel: reset, vector table, hand-written corner sequences and
// randomized traffic compared against a behavioural model of the call panel.
module tb_elevator_call_panel;

   localparam int FLOORS    = 8;
   localparam int POS_W     = 3;
   localparam int DEBOUNCE  = 4;
   localparam int DEB_W     = 3;
   localparam int CHIME_LEN = 3;
   localparam int LAT       = DEBOUNCE + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   elevator_call_panel_if #(.FLOORS(FLOORS), .POS_W(POS_W)) bus ();

   elevator_call_panel #(
      .FLOORS    (FLOORS),
      .POS_W     (POS_W),
      .DEBOUNCE  (DEBOUNCE),
      .DEB_W     (DEB_W),
      .CHIME_LEN (CHIME_LEN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: each button is seen two cycles late; a new level is accepted once
   // it has been seen, uninterrupted, for DEBOUNCE consecutive cycles.
   logic [FLOORS-1:0] m_seen [0:1];
   logic [FLOORS-1:0] m_level;
   int                m_age [FLOORS];
   logic [FLOORS-1:0] m_req;
   logic [FLOORS-1:0] m_lamp;
   logic              m_door_prev;
   int                m_chime_left;

   task automatic model_step();
      logic [FLOORS-1:0] rising;
      logic [FLOORS-1:0] served;
      logic [FLOORS-1:0] fresh;
      logic [FLOORS-1:0] now_seen;
      if (rst) begin
         m_seen[0] = '0; m_seen[1] = '0; m_level = '0;
         for (int f = 0; f < FLOORS; f++) m_age[f] = 0;
         m_req = '0; m_lamp = '0; m_door_prev = 1'b0; m_chime_left = 0;
         return;
      end
      now_seen = m_seen[1];
      rising = '0;
      served = '0;
      for (int f = 0; f < FLOORS; f++) begin
         if (bus.door_open && int'(bus.floor_pos) == f) served[f] = 1'b1;
         if (now_seen[f] == m_level[f]) begin
            m_age[f] = 0;
         end else begin
            m_age[f] = m_age[f] + 1;
            if (m_age[f] >= DEBOUNCE) begin
               if (now_seen[f]) rising[f] = 1'b1;
               m_level[f] = now_seen[f];
               m_age[f]   = 0;
            end
         end
      end
      fresh  = rising & ~m_lamp & ~served;
      m_req  = fresh;
      m_lamp = (m_lamp | fresh) & ~served;
      m_seen[1] = m_seen[0];
      m_seen[0] = bus.btn_raw;
`ifdef ARRIVAL_CHIME_EN
      if (bus.door_open && !m_door_prev) m_chime_left = CHIME_LEN;
      else if (m_chime_left > 0) m_chime_left = m_chime_left - 1;
`endif
      m_door_prev = bus.door_open;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.btn_raw = '0; bus.door_open = 1'b0; bus.floor_pos = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   typedef struct {
      logic [FLOORS-1:0] btn;
      logic [POS_W-1:0]  pos;
      logic              door;
      logic [FLOORS-1:0] req;
      logic [FLOORS-1:0] lamp;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int cnt;
      int at;
      logic [FLOORS-1:0] acc_req;
      logic [FLOORS-1:0] acc_lamp;
      logic exp_chime;

      // Clean press of floor 3, then service at floor 3.
      tbl[0] = '{8'h08, 3'd0, 1'b0, 8'h00, 8'h00};
      tbl[1] = '{8'h08, 3'd0, 1'b0, 8'h00, 8'h00};
      tbl[2] = '{8'h08, 3'd0, 1'b0, 8'h00, 8'h00};
      tbl[3] = '{8'h08, 3'd0, 1'b0, 8'h00, 8'h00};
      tbl[4] = '{8'h08, 3'd0, 1'b0, 8'h00, 8'h00};
      tbl[5] = '{8'h08, 3'd0, 1'b0, 8'h08, 8'h08};
      tbl[6] = '{8'h08, 3'd0, 1'b0, 8'h00, 8'h08};
      tbl[7] = '{8'h00, 3'd3, 1'b1, 8'h00, 8'h00};
      tbl[8] = '{8'h00, 3'd0, 1'b0, 8'h00, 8'h00};

      bus.btn_raw = 8'hFF; bus.floor_pos = '0; bus.door_open = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_req", 32'(bus.floor_req), 32'h0);
         chk("rst_lamp", 32'(bus.call_lamp), 32'h0);
         chk("rst_chime", 32'(bus.chime), 32'h0);
      end
      // Partial debounce interrupted by reset must not produce a pulse.
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("partial_req", 32'(bus.floor_req), 32'h0);
      end
      rst = 1'b1;
      tick();
      chk("rst_mid_req", 32'(bus.floor_req), 32'h0);
      rst = 1'b0;
      for (int k = 0; k <= LAT; k++) begin
         tick();
         chk("rst_latency", 32'(bus.floor_req), (k == LAT) ? 32'hFF : 32'h0);
      end
      bus.btn_raw = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(4);

      for (int i = 0; i < 9; i++) begin
         bus.btn_raw = tbl[i].btn; bus.floor_pos = tbl[i].pos; bus.door_open = tbl[i].door;
         tick();
         chk($sformatf("tbl%0d_req", i), 32'(bus.floor_req), 32'(tbl[i].req));
         chk($sformatf("tbl%0d_lamp", i), 32'(bus.call_lamp), 32'(tbl[i].lamp));
      end
      idle(8);

      // Bouncing floor 2: 2-cycle runs never qualify; the final steady press gives one pulse.
      cnt = 0; at = -1;
      for (int i = 0; i < 30; i++) begin
         bus.btn_raw = (i >= 12) ? 8'h04 : (((i / 2) % 2 == 0) ? 8'h04 : 8'h00);
         tick();
         if (bus.floor_req[2]) begin cnt++; at = i; end
      end
      chk("bounce_count", 32'(cnt), 32'd1);
      chk("bounce_edge", 32'(at), 32'(12 + LAT));
      bus.btn_raw = '0; bus.floor_pos = 3'd2; bus.door_open = 1'b1;
      tick();
      idle(8);

      // Service at floor 5, then a press there while the door is open.
      bus.btn_raw = 8'h20;
      for (int i = 0; i < 7; i++) tick();
      chk("svc_lamp_set", 32'(bus.call_lamp), 32'h20);
      bus.btn_raw = 8'h00;
      for (int i = 0; i < 7; i++) tick();
      chk("svc_release_keeps", 32'(bus.call_lamp), 32'h20);
      bus.floor_pos = 3'd5; bus.door_open = 1'b1;
      tick();
      chk("svc_clear", 32'(bus.call_lamp), 32'h00);
      bus.btn_raw = 8'h20;
      acc_req = '0; acc_lamp = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         acc_req |= bus.floor_req; acc_lamp |= bus.call_lamp;
      end
      chk("svc_open_req", 32'(acc_req), 32'h0);
      chk("svc_open_lamp", 32'(acc_lamp), 32'h0);
      bus.btn_raw = 8'h00;
      for (int i = 0; i < 7; i++) tick();
      idle(4);

      // Floor 1: re-press while lit is ignored; after service a re-press pulses again.
      cnt = 0;
      for (int ph = 0; ph < 3; ph++) begin
         bus.btn_raw = (ph == 1) ? 8'h00 : 8'h02;
         for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.floor_req[1]) cnt++;
         end
      end
      chk("repeat_lit_pulses", 32'(cnt), 32'd1);
      chk("repeat_lit_lamp", 32'(bus.call_lamp), 32'h02);
      bus.btn_raw = 8'h00; bus.floor_pos = 3'd1; bus.door_open = 1'b1;
      tick();
      bus.door_open = 1'b0; bus.floor_pos = 3'd0;
      for (int i = 0; i < 7; i++) tick();
      chk("repeat_served_lamp", 32'(bus.call_lamp), 32'h00);
      cnt = 0;
      bus.btn_raw = 8'h02;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (bus.floor_req[1]) cnt++;
      end
      chk("repeat_after_svc", 32'(cnt), 32'd1);
      idle(8);

      // Arrival chime after a door_open rise.
      bus.floor_pos = 3'd4; bus.door_open = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
`ifdef ARRIVAL_CHIME_EN
         exp_chime = (k < CHIME_LEN);
`else
         exp_chime = 1'b0;
`endif
         chk($sformatf("chime_%0d", k), 32'(bus.chime), 32'(exp_chime));
      end
      idle(6);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         logic [FLOORS-1:0] flips;
         flips = '0;
         for (int f = 0; f < FLOORS; f++) if ($urandom_range(0, 11) == 0) flips[f] = 1'b1;
         bus.btn_raw = bus.btn_raw ^ flips;
         if ($urandom_range(0, 7) == 0) bus.floor_pos = POS_W'($urandom_range(0, FLOORS - 1));
         if ($urandom_range(0, 9) == 0) bus.door_open = ~bus.door_open;
         rst = ($urandom_range(0, 599) == 0);
         tick();
         chk("rand_req", 32'(bus.floor_req), 32'(m_req));
         chk("rand_lamp", 32'(bus.call_lamp), 32'(m_lamp));
         chk("rand_chime", 32'(bus.chime), 32'(m_chime_left > 0));
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
